// File: rtl/plot_shadow_buffer.sv
// Shadow copy of the pixel-plot framebuffer with rectangular collision probes.
// Each probe scans an XDIM x YDIM cell and reports the first non-background or off-screen pixel.
module plot_shadow_buffer #(
    parameter int         XSCREEN = 160,
    parameter int         YSCREEN = 120,
    parameter int         XDIM    = 10,
    parameter int         YDIM    = 10,
    parameter logic [2:0] BG      = 3'b000
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
    input  logic       probe_req,
    input  logic [7:0] probe_x,
    input  logic [6:0] probe_y,
    output logic       probe_busy,
    output logic       probe_done,
    output logic       probe_hit,
    output logic [2:0] probe_colour
);

    localparam int          DEPTH    = XSCREEN * YSCREEN;
    localparam logic [8:0]  XS       = 9'(XSCREEN);
    localparam logic [7:0]  YS       = 8'(YSCREEN);
    localparam logic [7:0]  XL       = 8'(XDIM - 1);
    localparam logic [6:0]  YL       = 7'(YDIM - 1);
    localparam logic [14:0] CLR_LAST = 15'(DEPTH - 1);
    localparam logic [2:0]  OFF_COL  = 3'b111;

    typedef enum logic [1:0] {CLEAR, IDLE, SCAN, DONE} state_t;

    function automatic logic [14:0] addr_of(input logic [7:0] ax, input logic [6:0] ay);
        return {1'b0, ay, 7'b0} + {3'b0, ay, 5'b0} + {7'b0, ax};
    endfunction

    state_t      state;
    logic [14:0] clr_addr;
    logic [7:0]  px, xc;
    logic [6:0]  py, yc;
    logic        issuing;
    logic        s1_valid, s1_off, s1_last;

    logic        plot_ok;
    logic        we;
    logic [14:0] wa, ra;
    logic [2:0]  wd, rd_data;
    logic [8:0]  pxs;
    logic [7:0]  pys;
    logic        off;
    logic [2:0]  pix;
    logic        pix_hit;

    assign plot_ok = plot && ({1'b0, x} < XS) && ({1'b0, y} < YS);

    // Plot writes take the port; the clear counter simply waits for a free cycle.
    assign we = plot_ok || (state == CLEAR);
    assign wa = plot_ok ? addr_of(x, y) : clr_addr;
    assign wd = plot_ok ? colour : BG;

    assign pxs = {1'b0, px} + {1'b0, xc};
    assign pys = {1'b0, py} + {1'b0, yc};
    assign off = (pxs >= XS) || (pys >= YS);
    assign ra  = off ? '0 : addr_of(pxs[7:0], pys[6:0]);

    assign pix     = s1_off ? OFF_COL : rd_data;
    assign pix_hit = s1_valid && (pix != BG);

    logic [2:0] mem [DEPTH];

    // Read returns the pre-write contents on an address collision.
    always_ff @(posedge Clock) begin
        if (we) mem[wa] <= wd;
        rd_data <= mem[ra];
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state        <= CLEAR;
            clr_addr     <= '0;
            probe_busy   <= 1'b1;
            probe_done   <= 1'b0;
            probe_hit    <= 1'b0;
            probe_colour <= BG;
            px           <= '0;
            py           <= '0;
            xc           <= '0;
            yc           <= '0;
            issuing      <= 1'b0;
            s1_valid     <= 1'b0;
            s1_off       <= 1'b0;
            s1_last      <= 1'b0;
        end else begin
            probe_done <= 1'b0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            case (state)
                CLEAR: begin
                    if (!plot_ok) begin
                        if (clr_addr == CLR_LAST) begin
                            state      <= IDLE;
                            probe_busy <= 1'b0;
                        end else begin
                            clr_addr <= clr_addr + 15'd1;
                        end
                    end
                end
                IDLE: begin
                    if (probe_req) begin
                        px           <= probe_x;
                        py           <= probe_y;
                        xc           <= '0;
                        yc           <= '0;
                        issuing      <= 1'b1;
                        probe_hit    <= 1'b0;
                        probe_colour <= BG;
                        probe_busy   <= 1'b1;
                        state        <= SCAN;
                    end
                end
                SCAN: begin
                    // Issue stage: one pixel per cycle, off-screen pixels skip the RAM.
                    if (issuing) begin
                        s1_valid <= 1'b1;
                        s1_off   <= off;
                        s1_last  <= (xc == XL) && (yc == YL);
                        if (xc == XL) begin
                            xc <= '0;
                            if (yc == YL) issuing <= 1'b0;
                            else          yc <= yc + 7'd1;
                        end else begin
                            xc <= xc + 8'd1;
                        end
                    end
                    // Evaluate stage, one cycle behind; raster order keeps the first hit.
                    if (pix_hit && !probe_hit) begin
                        probe_hit    <= 1'b1;
                        probe_colour <= pix;
                    end
                    if (s1_valid && s1_last) begin
                        state      <= DONE;
                        probe_done <= 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    probe_busy <= 1'b0;
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_plot_shadow_buffer.sv
// Directed bench for plot_shadow_buffer: clear timing, probe latency/results, off-screen and reset abort.
module tb_plot_shadow_buffer;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b1;
    logic [7:0] x = '0;
    logic [6:0] y = '0;
    logic [2:0] colour = '0;
    logic       plot = 1'b0;
    logic       probe_req = 1'b0;
    logic [7:0] probe_x = '0;
    logic [6:0] probe_y = '0;
    logic       probe_busy, probe_done, probe_hit;
    logic [2:0] probe_colour;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    plot_shadow_buffer dut (
        .Clock(Clock), .Resetn(Resetn), .x(x), .y(y), .colour(colour), .plot(plot),
        .probe_req(probe_req), .probe_x(probe_x), .probe_y(probe_y),
        .probe_busy(probe_busy), .probe_done(probe_done),
        .probe_hit(probe_hit), .probe_colour(probe_colour)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Leaves the caller at the falling edge just after the reset edge.
    task automatic do_reset();
        @(negedge Clock);
        Resetn = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
    endtask

    // Counts falling edges with busy high; optionally plots 50 pixels starting 100 cycles in.
    task automatic count_busy(input bit with_plots, output int n, output bit saw_done);
        int i;
        n = 0;
        saw_done = 1'b0;
        while (probe_busy === 1'b1 && n < 25000) begin
            if (probe_done === 1'b1) saw_done = 1'b1;
            if (with_plots && n >= 100 && n < 150) begin
                i      = (n < 125) ? n - 100 : n - 125;
                plot   = 1'b1;
                colour = 3'b101;
                x      = 8'(i);
                y      = (n < 125) ? 7'd0 : 7'd100;
            end else begin
                plot = 1'b0;
            end
            n++;
            @(negedge Clock);
        end
        plot = 1'b0;
    endtask

    task automatic plot_px(input logic [7:0] px, input logic [6:0] py, input logic [2:0] c);
        @(negedge Clock);
        plot = 1'b1; x = px; y = py; colour = c;
        @(negedge Clock);
        plot = 1'b0;
    endtask

    // lat counts falling edges after the accepting edge k; done registered at edge k+101
    // is first sampled high at edge k+102, which is falling edge 101 here.
    task automatic do_probe(input string tag, input logic [7:0] px, input logic [6:0] py,
                            input logic exp_hit, input logic [2:0] exp_col);
        int lat;
        logic h;
        logic [2:0] c;
        @(negedge Clock);
        probe_req = 1'b1; probe_x = px; probe_y = py;
        @(negedge Clock);
        probe_req = 1'b0;
        lat = 0;
        while (probe_done !== 1'b1 && lat < 300) begin
            @(negedge Clock);
            lat++;
        end
        h = probe_hit;
        c = probe_colour;
        check({tag, "_latency"}, 32'(lat), 32'd101);
        check({tag, "_hit"}, 32'(h), 32'(exp_hit));
        check({tag, "_colour"}, 32'(c), 32'(exp_col));
        @(negedge Clock);
        check({tag, "_done_pulse"}, 32'(probe_done), 32'd0);
        check({tag, "_busy_low"}, 32'(probe_busy), 32'd0);
        check({tag, "_hold_hit"}, 32'(probe_hit), 32'(exp_hit));
    endtask

    initial begin
        int n;
        bit sd;

        repeat (2) @(negedge Clock);

        do_reset();
        check("rst_busy", 32'(probe_busy), 32'd1);
        check("rst_done", 32'(probe_done), 32'd0);
        check("rst_hit", 32'(probe_hit), 32'd0);
        check("rst_colour", 32'(probe_colour), 32'd0);
        count_busy(1'b0, n, sd);
        check("clear_len", 32'(n), 32'd19200);
        check("clear_no_done", 32'(sd), 32'd0);

        do_probe("empty00", 8'd0, 7'd0, 1'b0, 3'b000);

        plot_px(8'd85, 7'd65, 3'b010);
        do_probe("single", 8'd80, 7'd60, 1'b1, 3'b010);

        plot_px(8'd80, 7'd60, 3'b100);
        plot_px(8'd89, 7'd69, 3'b001);
        do_probe("first_wins", 8'd80, 7'd60, 1'b1, 3'b100);
        do_probe("neighbour", 8'd90, 7'd60, 1'b0, 3'b000);

        do_probe("corner_off", 8'd155, 7'd115, 1'b1, 3'b111);

        // x=160,y=5 would alias to (0,6) if it were written
        plot_px(8'd160, 7'd5, 3'b011);
        do_probe("right_edge", 8'd155, 7'd0, 1'b1, 3'b111);
        do_probe("no_alias", 8'd0, 7'd0, 1'b0, 3'b000);

        do_reset();
        count_busy(1'b1, n, sd);
        check("clear_stall_len", 32'(n), 32'd19250);
        do_probe("kept_plots", 8'd0, 7'd0, 1'b1, 3'b101);
        do_probe("erased_plots", 8'd0, 7'd100, 1'b0, 3'b000);

        // Reset lands on edge k+40 of a probe that has already found a hit.
        @(negedge Clock);
        probe_req = 1'b1; probe_x = 8'd0; probe_y = 7'd0;
        @(negedge Clock);
        probe_req = 1'b0;
        repeat (39) @(negedge Clock);
        Resetn = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        check("abort_busy", 32'(probe_busy), 32'd1);
        check("abort_done", 32'(probe_done), 32'd0);
        check("abort_hit", 32'(probe_hit), 32'd0);
        check("abort_colour", 32'(probe_colour), 32'd0);
        count_busy(1'b0, n, sd);
        check("abort_clear_len", 32'(n), 32'd19200);
        check("abort_no_done", 32'(sd), 32'd0);
        do_probe("after_abort", 8'd0, 7'd0, 1'b0, 3'b000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
